// File: rtl/store_pkg.sv
// Shared constants and state encoding for the sub-word store read-modify-write sequencer.
package store_pkg;

  localparam logic [2:0] FN3_SB = 3'b000;
  localparam logic [2:0] FN3_SH = 3'b001;
  localparam logic [2:0] FN3_SW = 3'b010;

  localparam logic [6:0] OPCODE_STORE = 7'b0100011;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_WAIT = 3'd2,
    ST_WR   = 3'd3,
    ST_RESP = 3'd4
  } state_t;

  // Unsupported width or a lane that straddles a word boundary.
  function automatic logic store_bad(input logic [2:0] fn3, input logic [1:0] lane);
    logic bad;
    bad = 1'b1;
    if (fn3 == FN3_SB) bad = 1'b0;
    else if (fn3 == FN3_SH) bad = lane[0];
    else if (fn3 == FN3_SW) bad = (lane != 2'b00);
    return bad;
  endfunction

endpackage

// File: rtl/store_lane_merge.sv
// Combinational lane merge: places a byte/halfword/word of rs2 into the read word.
module store_lane_merge
  import store_pkg::*;
(
  input  logic [2:0]  fn3,
  input  logic [1:0]  lane,
  input  logic [31:0] rd_word,
  input  logic [31:0] wdata,
  output logic [31:0] merged
);

  always_comb begin
    merged = rd_word;
    case (fn3)
      FN3_SB:  merged[{lane, 3'b000} +: 8]     = wdata[7:0];
      FN3_SH:  merged[{lane[1], 4'b0000} +: 16] = wdata[15:0];
      FN3_SW:  merged = wdata;
      default: merged = rd_word;
    endcase
  end

endmodule

// File: rtl/store_rmw_ctrl.sv
// Read-modify-write sequencer for sub-word stores to a word-wide data memory.
// Optional STORE_RMW_SW_FASTPATH_EN: aligned SW skips the read and writes directly.
//
// state   | meaning
// --------+---------------------------------------------------
// IDLE    | ready for a request; illegal requests go to RESP
// RD      | read strobe on mem_rd_en for the containing word
// WAIT    | waiting for mem_rd_valid, merge on arrival
// WR      | merged word on mem_wr_data with mem_wr_en
// RESP    | done pulse (with err for rejected requests)
module store_rmw_ctrl
  import store_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [2:0]        req_fn3,
  input  logic [DATA_W-1:0] req_data,
  output logic              mem_rd_en,
  input  logic              mem_rd_valid,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wr_data,
  output logic              done,
  output logic              err
);

  state_t state, next_state;

  logic [1:0]        lane_q;
  logic [2:0]        fn3_q;
  logic [DATA_W-1:0] data_q;

  logic              accept;
  logic              bad;
  logic [2:0]        m_fn3;
  logic [1:0]        m_lane;
  logic [DATA_W-1:0] m_data;
  logic [DATA_W-1:0] merged;

  assign req_ready = (state == ST_IDLE);
  assign accept    = req_valid && req_ready;
  assign bad       = store_bad(req_fn3, req_addr[1:0]);

  // The write word is formed on the transition into WR; from IDLE only the
  // fast path can get there, so the unlatched request fields are used then.
  assign m_fn3  = (state == ST_IDLE) ? req_fn3       : fn3_q;
  assign m_lane = (state == ST_IDLE) ? req_addr[1:0] : lane_q;
  assign m_data = (state == ST_IDLE) ? req_data      : data_q;

  store_lane_merge u_merge (
    .fn3     (m_fn3),
    .lane    (m_lane),
    .rd_word (mem_rd_data),
    .wdata   (m_data),
    .merged  (merged)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (bad) next_state = ST_RESP;
`ifdef STORE_RMW_SW_FASTPATH_EN
          else if (req_fn3 == FN3_SW) next_state = ST_WR;
`endif
          else next_state = ST_RD;
        end
      end
      ST_RD:   next_state = ST_WAIT;
      ST_WAIT: if (mem_rd_valid) next_state = ST_WR;
      ST_WR:   next_state = ST_RESP;
      ST_RESP: next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  // Strobes are registered from the next state so they line up with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lane_q      <= '0;
      fn3_q       <= '0;
      data_q      <= '0;
      mem_rd_en   <= 1'b0;
      mem_wr_en   <= 1'b0;
      mem_addr    <= '0;
      mem_wr_data <= '0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      if (accept) begin
        lane_q <= req_addr[1:0];
        fn3_q  <= req_fn3;
        data_q <= req_data;
        if (!bad) mem_addr <= {req_addr[ADDR_W-1:2], 2'b00};
      end
      mem_rd_en   <= (next_state == ST_RD);
      mem_wr_en   <= (next_state == ST_WR);
      mem_wr_data <= (next_state == ST_WR) ? merged : '0;
      done        <= (next_state == ST_RESP);
      err         <= accept && bad;
    end
  end

endmodule

// File: tb/tb_store_rmw_ctrl.sv
// Scoreboard bench for store_rmw_ctrl: directed cases, random stores, mid-read reset.
module tb_store_rmw_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [2:0]  req_fn3;
  logic [31:0] req_data;
  logic        mem_rd_en;
  logic        mem_rd_valid;
  logic [31:0] mem_rd_data;
  logic        mem_wr_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_wr_data;
  logic        done;
  logic        err;

  store_rmw_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_addr     (req_addr),
    .req_fn3      (req_fn3),
    .req_data     (req_data),
    .mem_rd_en    (mem_rd_en),
    .mem_rd_valid (mem_rd_valid),
    .mem_rd_data  (mem_rd_data),
    .mem_wr_en    (mem_wr_en),
    .mem_addr     (mem_addr),
    .mem_wr_data  (mem_wr_data),
    .done         (done),
    .err          (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

`ifdef STORE_RMW_SW_FASTPATH_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h (t=%0t)", name, got, want, $time);
    end
  endtask

  typedef struct {
    bit          is_err;
    bit          fast;
    logic [31:0] wdata;
    logic [31:0] waddr;
    int          done_cyc;
  } exp_t;

  typedef struct {
    int          lat;
    logic [31:0] word;
  } mem_t;

  exp_t sb[$];
  mem_t mq[$];

  function automatic bit model_bad(input logic [2:0] f, input logic [31:0] a);
    int width;
    width = (f == 3'd0) ? 1 : (f == 3'd1) ? 2 : (f == 3'd2) ? 4 : 0;
    if (width == 0) return 1'b1;
    return (a % width) != 0;
  endfunction

  function automatic logic [31:0] model_merge(input logic [2:0] f, input logic [31:0] a,
                                              input logic [31:0] d, input logic [31:0] rw);
    logic [7:0] b [4];
    int width, base;
    for (int i = 0; i < 4; i++) b[i] = rw[8*i +: 8];
    width = (f == 3'd0) ? 1 : (f == 3'd1) ? 2 : 4;
    base  = (a % 4) / width * width;
    for (int i = 0; i < width; i++) b[base + i] = d[8*i +: 8];
    return {b[3], b[2], b[1], b[0]};
  endfunction

  // Memory model: answers each read strobe after its programmed extra latency.
  initial begin
    mem_t m;
    mem_rd_valid = 1'b0;
    mem_rd_data  = '0;
    forever begin
      @(negedge clk);
      if (!rst && mem_rd_en) begin
        if (mq.size() == 0) chk("unexpected_read", {31'd0, mem_rd_en}, 32'd0);
        else begin
          m = mq.pop_front();
          @(posedge clk);
          repeat (m.lat) @(posedge clk);
          #1 mem_rd_valid = 1'b1;
          mem_rd_data = m.word;
          @(posedge clk);
          #1 mem_rd_valid = 1'b0;
          mem_rd_data = $urandom;
        end
      end
    end
  end

  int          rd_cnt = 0, wr_cnt = 0;
  logic [31:0] rd_addr_s, wr_addr_s, wr_data_s;

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      rd_cnt = 0;
      wr_cnt = 0;
    end else begin
      if (mem_rd_en) begin rd_cnt++; rd_addr_s = mem_addr; end
      if (mem_wr_en) begin wr_cnt++; wr_addr_s = mem_addr; wr_data_s = mem_wr_data; end
      if (err) chk("err_qualifies_done", {31'd0, done}, 32'd1);
      if (done) begin
        if (sb.size() == 0) chk("unexpected_done", {31'd0, done}, 32'd0);
        else begin
          e = sb.pop_front();
          chk("err", {31'd0, err}, {31'd0, e.is_err});
          chk("done_cycle", cyc, e.done_cyc);
          if (e.is_err) begin
            chk("err_rd_cnt", rd_cnt, 0);
            chk("err_wr_cnt", wr_cnt, 0);
          end else begin
            chk("wr_cnt", wr_cnt, 1);
            chk("rd_cnt", rd_cnt, e.fast ? 0 : 1);
            chk("wr_data", wr_data_s, e.wdata);
            chk("wr_addr", wr_addr_s, e.waddr);
            if (!e.fast) chk("rd_addr", rd_addr_s, e.waddr);
          end
        end
        rd_cnt = 0;
        wr_cnt = 0;
      end
    end
  end

  task automatic issue(input logic [31:0] a, input logic [2:0] f, input logic [31:0] d,
                       input int lat, input logic [31:0] rw, input bit hold, output int acc);
    exp_t e;
    bit   bad, fast;
    int   w;
    @(negedge clk);
    req_valid = 1'b1;
    req_addr  = a;
    req_fn3   = f;
    req_data  = d;
    bad  = model_bad(f, a);
    fast = FAST && (f == 3'd2) && !bad;
    if (!bad && !fast) mq.push_back('{lat, rw});
    w = 0;
    while (!req_ready && w < 200) begin @(negedge clk); w++; end
    if (!req_ready) begin
      chk("accept_timeout", {31'd0, req_ready}, 32'd1);
      req_valid = 1'b0;
      acc = -1;
      return;
    end
    acc = cyc + 1;
    e.is_err   = bad;
    e.fast     = fast;
    e.wdata    = model_merge(f, a, d, rw);
    e.waddr    = {a[31:2], 2'b00};
    e.done_cyc = bad ? acc : fast ? acc + 1 : acc + 3 + lat;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (!hold) req_valid = 1'b0;
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_req_ready"}, {31'd0, req_ready}, 32'd1);
    chk({tag, "_rd_en"}, {31'd0, mem_rd_en}, 32'd0);
    chk({tag, "_wr_en"}, {31'd0, mem_wr_en}, 32'd0);
    chk({tag, "_mem_addr"}, mem_addr, 32'd0);
    chk({tag, "_wr_data"}, mem_wr_data, 32'd0);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
    chk({tag, "_err"}, {31'd0, err}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int a1, a2, acc, n, w;
    bit hold;
    logic [2:0] f;
    rst = 1'b1;
    req_valid = 1'b0;
    req_addr = '0;
    req_fn3 = '0;
    req_data = '0;
    repeat (3) @(negedge clk);
    chk_reset_values("reset");
    rst = 1'b0;

    issue(32'h1002, 3'b000, 32'h0000_00AB, 0, 32'h1122_3344, 1'b0, acc);
    issue(32'h1002, 3'b001, 32'h0000_BEEF, 0, 32'h1122_3344, 1'b0, acc);
    issue(32'h1000, 3'b001, 32'h0000_BEEF, 1, 32'h1122_3344, 1'b0, acc);
    issue(32'h1001, 3'b001, 32'h0000_BEEF, 0, 32'h1122_3344, 1'b0, acc);
    issue(32'h1000, 3'b011, 32'h0000_BEEF, 0, 32'h1122_3344, 1'b0, acc);
    issue(32'h2000, 3'b010, 32'hDEAD_BEEF, 0, 32'h5555_AAAA, 1'b0, acc);
    issue(32'h2002, 3'b010, 32'hDEAD_BEEF, 0, 32'h5555_AAAA, 1'b0, acc);

    // Held request behind a slow read: accepted in the cycle after done.
    issue(32'h3001, 3'b000, 32'h0000_005A, 3, 32'hCAFE_F00D, 1'b1, a1);
    issue(32'h3006, 3'b001, 32'h0000_1234, 3, 32'h0BAD_F00D, 1'b0, a2);
    chk("b2b_accept", a2, a1 + 8);

    n = 150;
    for (int i = 0; i < n; i++) begin
      f = ($urandom_range(7) < 6) ? 3'($urandom_range(2)) : 3'($urandom_range(7));
      hold = (i < n - 1) && ($urandom_range(1) == 1);
      issue($urandom, f, $urandom, $urandom_range(3), $urandom, hold, acc);
      if (!hold) repeat ($urandom_range(2)) @(negedge clk);
    end

    w = 0;
    while (sb.size() != 0 && w < 200) begin @(negedge clk); w++; end
    chk("drain", sb.size(), 0);

    // Reset while waiting on a long read: the late read data must not cause a write.
    issue(32'h4003, 3'b000, 32'h0000_0077, 20, 32'h1234_5678, 1'b0, acc);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    sb.delete();
    chk_reset_values("mid_reset");
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    #2;
    chk("no_wr_after_reset", wr_cnt, 0);
    chk("ready_after_reset", {31'd0, req_ready}, 32'd1);
    chk("no_pending_read", mq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
